addrc_controller: RTL and testbench

ADDRC_CONTROLLER -- requirements
Module: addrc_controller

---
 rtl/addrc_controller.sv | 147 ++++++++++++++
 tb/tb_addrc_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addrc_controller.sv
`default_nettype none
// ============================================================================
// Module      : addrc_controller
// Description : Control FSM for a slice-serial round-constant stage. It
//               sequences one 64-slice state through a two-deep handshake:
//               FILL takes one upstream slice into the datapath output
//               register, and DRAIN holds that slice until downstream takes
//               it, then advances the datapath slice counter.
//
//   Ports
//     clk, rst        : clock, asynchronous active-high reset
//     start, roundIn  : operation request and round index (sampled in IDLE)
//     abort           : synchronous cancel of an operation in progress
//     inValid         : upstream slice valid
//     outReady        : downstream accepts the registered slice
//     sliceCntCo      : datapath slice counter is at 63
//     inReady         : block accepts an upstream slice
//     outValid        : datapath output register holds a processed slice
//     sliceCntEn/Clr  : datapath slice counter increment / clear
//     ldReg/clrReg    : datapath output register load / clear
//     cycleNum        : latched round index (round-constant select)
//     busy            : operation in progress (every state except IDLE)
//     done            : one-cycle pulse after the 64th slice is drained
//     err             : one-cycle pulse after a rejected start
//
// Revision    : 1.0 - initial release
// ============================================================================
module addrc_controller #(
    parameter int ROUNDS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] roundIn,
    input  logic       abort,
    input  logic       inValid,
    input  logic       outReady,
    input  logic       sliceCntCo,
    output logic       inReady,
    output logic       outValid,
    output logic       sliceCntEn,
    output logic       sliceCntClr,
    output logic       ldReg,
    output logic       clrReg,
    output logic [4:0] cycleNum,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Six bits so that ROUNDS = 32 (every 5-bit index valid) still compares
    // correctly.
    localparam logic [5:0] C_ROUNDS = 6'(ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_FILL  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cycle_num_q, cycle_num_d;
    logic       err_q, err_d;

    logic       w_round_ok;
    logic       w_active;
    logic       w_abort;

    assign w_round_ok = ({1'b0, roundIn} < C_ROUNDS);
    assign w_active   = (state_q == ST_INIT) || (state_q == ST_FILL) ||
                        (state_q == ST_DRAIN);
    // Abort only acts while an operation is in flight; IDLE and DONE ignore it.
    assign w_abort    = abort && w_active;

    always_comb begin
        state_d     = state_q;
        cycle_num_d = cycle_num_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (w_round_ok) begin
                        cycle_num_d = roundIn;
                        state_d     = ST_INIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                state_d = w_abort ? ST_IDLE : ST_FILL;
            end
            ST_FILL: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else if (inValid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_abort) begin
                    state_d = ST_IDLE;
                end else if (outReady) begin
                    // The counter wraps 63->0 on this same increment, so the
                    // next operation starts at slice 0 without a clear here.
                    state_d = sliceCntCo ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cycle_num_q <= 5'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_num_q <= cycle_num_d;
            err_q       <= err_d;
        end
    end

    // Load and increment live in different states, so they can never coincide;
    // each loaded slice therefore sees the counter value of its own position.
    assign ldReg       = (state_q == ST_FILL)  && inValid  && !abort;
    assign sliceCntEn  = (state_q == ST_DRAIN) && outReady && !abort;

    assign inReady     = (state_q == ST_FILL);
    assign outValid    = (state_q == ST_DRAIN);
    assign sliceCntClr = (state_q == ST_INIT) || w_abort;
    assign clrReg      = (state_q == ST_INIT) || w_abort;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign cycleNum    = cycle_num_q;

endmodule
`default_nettype wire

// File: tb/tb_addrc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_addrc_controller
// Description : Self-checking bench for addrc_controller. A transaction-level
//               model (operation active, slices loaded, slices sent) predicts
//               every output each cycle; a small slice counter stands in for
//               the datapath and supplies sliceCntCo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addrc_controller;

    localparam int ROUNDS = 24;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] roundIn;
    logic       abort;
    logic       inValid;
    logic       outReady;
    logic       sliceCntCo;
    logic       inReady;
    logic       outValid;
    logic       sliceCntEn;
    logic       sliceCntClr;
    logic       ldReg;
    logic       clrReg;
    logic [4:0] cycleNum;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    addrc_controller #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .roundIn    (roundIn),
        .abort      (abort),
        .inValid    (inValid),
        .outReady   (outReady),
        .sliceCntCo (sliceCntCo),
        .inReady    (inReady),
        .outValid   (outValid),
        .sliceCntEn (sliceCntEn),
        .sliceCntClr(sliceCntClr),
        .ldReg      (ldReg),
        .clrReg     (clrReg),
        .cycleNum   (cycleNum),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in datapath slice counter sharing the design's reset.
    logic [5:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_cnt <= 6'd0;
        else if (sliceCntClr) r_cnt <= 6'd0;
        else if (sliceCntEn)  r_cnt <= r_cnt + 6'd1;
    end
    assign sliceCntCo = (r_cnt == 6'd63);

    // ---------------- transaction-level reference model ----------------
    logic       m_op;      // operation accepted and not yet finished
    logic       m_init;    // first cycle after acceptance
    logic       m_done;    // all 64 slices sent, completion cycle
    logic       m_err;
    int         m_loaded;
    int         m_sent;
    logic [4:0] m_cyc;

    function automatic logic m_fill();
        return m_op && !m_init && !m_done && (m_loaded == m_sent);
    endfunction

    function automatic logic m_drain();
        return m_op && !m_init && !m_done && (m_loaded > m_sent);
    endfunction

    function automatic logic [13:0] model_exp();
        logic f, d, ab;
        f  = m_fill();
        d  = m_drain();
        ab = abort && (m_init || f || d);
        return {f, d, d && outReady && !ab, m_init || ab, f && inValid && !ab,
                m_init || ab, m_op, m_done, m_err, m_cyc};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {inReady, outValid, sliceCntEn, sliceCntClr, ldReg, clrReg,
                busy, done, err, cycleNum};
    endfunction

    task automatic model_reset();
        m_op = 0; m_init = 0; m_done = 0; m_err = 0;
        m_loaded = 0; m_sent = 0; m_cyc = 5'd0;
    endtask

    task automatic model_advance();
        logic f, d, ab;
        f  = m_fill();
        d  = m_drain();
        ab = abort && (m_init || f || d);
        m_err = !m_op && start && (int'(roundIn) >= ROUNDS);
        if (!m_op) begin
            if (start && int'(roundIn) < ROUNDS) begin
                m_op = 1; m_init = 1; m_loaded = 0; m_sent = 0; m_cyc = roundIn;
            end
        end else if (m_done) begin
            m_op = 0; m_done = 0;
        end else if (ab) begin
            m_op = 0; m_init = 0;
        end else if (m_init) begin
            m_init = 0;
        end else if (f && inValid) begin
            m_loaded++;
        end else if (d && outReady) begin
            m_sent++;
            if (m_sent == 64) m_done = 1;
        end
    endtask

    // Advance one clock: the model moves with the edge, inputs change on negedge.
    task automatic step();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        start = 0; roundIn = 5'd0; abort = 0; inValid = 0; outReady = 0;
    endtask

    // ---------------------------- tests ----------------------------
    task automatic test_reset();
        drive_idle();
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (dut_vec() !== 14'd0)
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 14'd0);
        else n_pass++;
        @(negedge clk);
        rst = 0;
    endtask

    // Full operation with inValid/outReady held high; optionally keep start high.
    task automatic test_full_run(input logic [4:0] rnd, input logic hold);
        logic [13:0] exp;
        int          done_at;
        int          n_done;
        done_at = -1;
        n_done  = 0;
        for (int t = 0; t <= 132; t++) begin
            start    = (t == 0) ? 1'b1 : (hold && t < 132);
            roundIn  = rnd;
            abort    = (t == 132);
            inValid  = 1;
            outReady = 1;
            #1;
            exp = model_exp();
            n_checks++;
            if (dut_vec() !== exp)
                $display("FAIL full_run t=%0d: got %h expected %h", t, dut_vec(), exp);
            else n_pass++;
            if (done) begin
                n_done++;
                done_at = t;
            end
            if (t == 131) begin
                n_checks++;
                if (busy !== 1'b0)
                    $display("FAIL full_run_idle_after_done: got busy=%b expected 0", busy);
                else n_pass++;
            end
            if (t == 132 && hold) begin
                n_checks++;
                if (busy !== 1'b1)
                    $display("FAIL start_held_restart: got busy=%b expected 1", busy);
                else n_pass++;
            end
            step();
        end
        n_checks++;
        if (done_at != 130 || n_done != 1)
            $display("FAIL full_run_done_timing: got done at %0d (%0d pulses) expected 130 (1)",
                     done_at, n_done);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_reject();
        logic [13:0] exp;
        for (int k = 0; k < 3; k++) begin
            logic [4:0] rnd;
            rnd = (k == 0) ? 5'd24 : 5'($urandom_range(24, 31));
            for (int t = 0; t < 3; t++) begin
                start   = (t == 0);
                roundIn = rnd;
                #1;
                exp = model_exp();
                n_checks++;
                if (dut_vec() !== exp)
                    $display("FAIL reject r=%0d t=%0d: got %h expected %h", rnd, t, dut_vec(), exp);
                else n_pass++;
                if (t == 1) begin
                    n_checks++;
                    if (err !== 1'b1 || busy !== 1'b0)
                        $display("FAIL reject_err r=%0d: got err=%b busy=%b expected err=1 busy=0",
                                 rnd, err, busy);
                    else n_pass++;
                end
                step();
            end
        end
        drive_idle();
    endtask

    task automatic test_random_stalls();
        logic [13:0] exp;
        int          n_ld, n_en, n_done, t;
        n_ld = 0; n_en = 0; n_done = 0;
        // Abort while idle must be a no-op.
        abort = 1;
        #1;
        exp = model_exp();
        n_checks++;
        if (dut_vec() !== exp)
            $display("FAIL idle_abort: got %h expected %h", dut_vec(), exp);
        else n_pass++;
        step();
        abort   = 0;
        start   = 1;
        roundIn = 5'($urandom_range(0, ROUNDS - 1));
        step();
        start = 0;
        t = 0;
        while (m_op && t < 3000) begin
            inValid  = 1'($urandom_range(0, 1));
            outReady = 1'($urandom_range(0, 1));
            #1;
            exp = model_exp();
            n_checks++;
            if (dut_vec() !== exp)
                $display("FAIL stalls t=%0d: got %h expected %h", t, dut_vec(), exp);
            else n_pass++;
            if (ldReg) begin
                n_checks++;
                if (r_cnt !== 6'(m_loaded))
                    $display("FAIL load_index: got counter %0d expected %0d", r_cnt, m_loaded % 64);
                else n_pass++;
                n_ld++;
            end
            if (sliceCntEn) n_en++;
            if (done) n_done++;
            step();
            t++;
        end
        n_checks++;
        if (m_op || n_ld != 64 || n_en != 64 || n_done != 1)
            $display("FAIL stalls_totals: got ld=%0d en=%0d done=%0d expected 64 64 1",
                     n_ld, n_en, n_done);
        else n_pass++;
        n_checks++;
        if (r_cnt !== 6'd0)
            $display("FAIL counter_wrap: got %0d expected 0", r_cnt);
        else n_pass++;
        drive_idle();
    endtask

    task automatic test_abort();
        logic [13:0] exp;
        logic        hit;
        hit = 0;
        start = 1; roundIn = 5'd7; inValid = 1; outReady = 1;
        step();
        start = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            abort = m_drain() && (m_sent == 30);
            #1;
            exp = model_exp();
            n_checks++;
            if (dut_vec() !== exp)
                $display("FAIL abort_run t=%0d: got %h expected %h", t, dut_vec(), exp);
            else n_pass++;
            if (abort) begin
                hit = 1;
                n_checks++;
                if (sliceCntEn !== 1'b0 || sliceCntClr !== 1'b1 || clrReg !== 1'b1)
                    $display("FAIL abort_cycle: got en=%b cntclr=%b regclr=%b expected 0 1 1",
                             sliceCntEn, sliceCntClr, clrReg);
                else n_pass++;
            end
            step();
        end
        abort = 0;
        for (int t = 0; t < 4; t++) begin
            #1;
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0 || !hit)
                $display("FAIL abort_after t=%0d: got busy=%b done=%b expected 0 0", t, busy, done);
            else n_pass++;
            step();
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        logic [13:0] exp;
        logic        hit;
        hit = 0;
        start = 1; roundIn = 5'd3; inValid = 1; outReady = 1;
        step();
        start = 0;
        for (int t = 0; t < 100 && !hit; t++) begin
            #1;
            exp = model_exp();
            n_checks++;
            if (dut_vec() !== exp)
                $display("FAIL pre_reset t=%0d: got %h expected %h", t, dut_vec(), exp);
            else n_pass++;
            if (m_fill() && m_loaded == 10) hit = 1;
            else step();
        end
        // Mid-cycle, well away from either clock edge.
        #1 rst = 1;
        #1;
        n_checks++;
        if (dut_vec() !== 14'd0 || r_cnt !== 6'd0 || !hit)
            $display("FAIL async_reset: got %h cnt=%0d expected 0 0", dut_vec(), r_cnt);
        else n_pass++;
        model_reset();
        drive_idle();
        @(negedge clk);
        rst = 0;
        test_full_run(5'd0, 1'b0);
    endtask

    initial begin
        rst = 1;
        drive_idle();
        model_reset();
        test_reset();
        test_full_run(5'd5, 1'b0);
        test_reject();
        test_random_stalls();
        test_random_stalls();
        test_abort();
        test_async_reset();
        test_full_run(5'd23, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
